servo_driver: RTL and testbench



---
 rtl/servo_pkg.sv | 19 +
 rtl/servo_channel.sv | 84 ++++++++
 rtl/servo_driver.sv | 83 ++++++++
 tb/tb_servo_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types, button encodings and default 50 MHz timing for the servo_driver slice.
package servo_pkg;

    typedef logic [7:0] pos_t;

    localparam logic [1:0] BTN_IDLE = 2'b00;
    localparam logic [1:0] BTN_ADD  = 2'b01;
    localparam logic [1:0] BTN_SUB  = 2'b10;

    localparam int unsigned STEP_DIV_DEF   = 500000;
    localparam int unsigned PWM_PERIOD_DEF = 1000000;
    localparam int unsigned MIN_PULSE_DEF  = 50000;
    localparam int unsigned PULSE_STEP_DEF = 196;

    localparam pos_t POS_INIT_DEF = 8'd128;
    localparam pos_t POS_MIN_DEF  = 8'd0;
    localparam pos_t POS_MAX_DEF  = 8'd255;

endpackage

// File: rtl/servo_channel.sv
// One servo: saturating position integrator, frame-start width latch and PWM comparator.
// Defining SERVO_SOFT_LIMIT_EN clamps steps to POS_MIN..POS_MAX instead of 0..255.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE  = MIN_PULSE_DEF,
    parameter int unsigned PULSE_STEP = PULSE_STEP_DEF,
    parameter pos_t        POS_INIT   = POS_INIT_DEF,
    parameter pos_t        POS_MIN    = POS_MIN_DEF,
    parameter pos_t        POS_MAX    = POS_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic        i_frameStart,
    input  logic [31:0] i_pwmCnt,
    input  logic [1:0]  i_btn,
    output pos_t        o_pos,
    output logic        o_pwm
);

`ifdef SERVO_SOFT_LIMIT_EN
    localparam pos_t LIM_LO = POS_MIN;
    localparam pos_t LIM_HI = POS_MAX;
`else
    localparam pos_t LIM_LO = 8'd0;
    localparam pos_t LIM_HI = 8'd255;
    logic w_unusedLimits;
    assign w_unusedLimits = ^{POS_MIN, POS_MAX};
`endif

    localparam logic [31:0] WIDTH_INIT = MIN_PULSE + 32'(POS_INIT) * PULSE_STEP;

    pos_t        r_pos;
    pos_t        w_posNext;
    logic [31:0] r_width;
    logic [31:0] w_widthNew;
    logic [31:0] w_widthEff;
    logic        r_pwm;

    always_comb begin
        w_posNext = r_pos;
        if (i_tick) begin
`ifdef SERVO_SOFT_LIMIT_EN
            // Out-of-range positions (POS_INIT included) drift back toward the window.
            if (r_pos < LIM_LO)
                w_posNext = r_pos + 8'd1;
            else if (r_pos > LIM_HI)
                w_posNext = r_pos - 8'd1;
            else
`endif
            if (i_btn == BTN_ADD && r_pos < LIM_HI)
                w_posNext = r_pos + 8'd1;
            else if (i_btn == BTN_SUB && r_pos > LIM_LO)
                w_posNext = r_pos - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pos <= POS_INIT;
        else
            r_pos <= w_posNext;
    end

    // The frame-start edge compares against the freshly computed width so the pulse starts there.
    assign w_widthNew = MIN_PULSE + 32'(r_pos) * PULSE_STEP;
    assign w_widthEff = i_frameStart ? w_widthNew : r_width;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= WIDTH_INIT;
            r_pwm   <= 1'b0;
        end else begin
            if (i_frameStart)
                r_width <= w_widthNew;
            r_pwm <= (i_pwmCnt < w_widthEff);
        end
    end

    assign o_pos = r_pos;
    assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_driver.sv
// Five-channel servo driver: shared step/frame counters feeding five servo_channel instances.
// Optional SERVO_SOFT_LIMIT_EN restricts positions to POS_MIN..POS_MAX.
module servo_driver
    import servo_pkg::*;
#(
    parameter int unsigned STEP_DIV   = STEP_DIV_DEF,
    parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int unsigned MIN_PULSE  = MIN_PULSE_DEF,
    parameter int unsigned PULSE_STEP = PULSE_STEP_DEF,
    parameter pos_t        POS_INIT   = POS_INIT_DEF,
    parameter pos_t        POS_MIN    = POS_MIN_DEF,
    parameter pos_t        POS_MAX    = POS_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn1,
    input  logic [1:0] btn2,
    input  logic [1:0] btn3,
    input  logic [1:0] btn4,
    input  logic [1:0] btn5,
    output pos_t       pos1,
    output pos_t       pos2,
    output pos_t       pos3,
    output pos_t       pos4,
    output pos_t       pos5,
    output logic [4:0] pwm
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [STEP_W-1:0] r_stepCnt;
    logic [PWM_W-1:0]  r_pwmCnt;
    logic              w_tick;
    logic              w_frameStart;
    logic              w_pwmWrap;
    logic [31:0]       w_pwmCnt32;
    logic [1:0]        w_btn [5];
    pos_t              w_pos [5];

    assign w_tick       = (r_stepCnt == STEP_W'(STEP_DIV - 1));
    assign w_pwmWrap    = (r_pwmCnt == PWM_W'(PWM_PERIOD - 1));
    assign w_frameStart = (r_pwmCnt == '0);
    assign w_pwmCnt32   = 32'(r_pwmCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stepCnt <= '0;
            r_pwmCnt  <= '0;
        end else begin
            r_stepCnt <= w_tick    ? '0 : r_stepCnt + STEP_W'(1);
            r_pwmCnt  <= w_pwmWrap ? '0 : r_pwmCnt + PWM_W'(1);
        end
    end

    assign w_btn = '{btn1, btn2, btn3, btn4, btn5};

    for (genvar gi = 0; gi < 5; gi++) begin : g_chan
        servo_channel #(
            .MIN_PULSE  (MIN_PULSE),
            .PULSE_STEP (PULSE_STEP),
            .POS_INIT   (POS_INIT),
            .POS_MIN    (POS_MIN),
            .POS_MAX    (POS_MAX)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_tick       (w_tick),
            .i_frameStart (w_frameStart),
            .i_pwmCnt     (w_pwmCnt32),
            .i_btn        (w_btn[gi]),
            .o_pos        (w_pos[gi]),
            .o_pwm        (pwm[gi])
        );
    end

    assign pos1 = w_pos[0];
    assign pos2 = w_pos[1];
    assign pos3 = w_pos[2];
    assign pos4 = w_pos[3];
    assign pos5 = w_pos[4];

endmodule

// File: tb/tb_servo_driver.sv
// Directed bench for servo_driver with shrunk timing: 4-clock steps, 600-clock frames, 16 + 2*pos pulses.
module tb_servo_driver;
    import servo_pkg::*;

    localparam int unsigned STEP_DIV   = 4;
    localparam int unsigned PWM_PERIOD = 600;
    localparam int unsigned MIN_PULSE  = 16;
    localparam int unsigned PULSE_STEP = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn1, btn2, btn3, btn4, btn5;
    pos_t       pos1, pos2, pos3, pos4, pos5;
    logic [4:0] pwm;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulseLen [5];

    servo_driver #(
        .STEP_DIV   (STEP_DIV),
        .PWM_PERIOD (PWM_PERIOD),
        .MIN_PULSE  (MIN_PULSE),
        .PULSE_STEP (PULSE_STEP),
        .POS_INIT   (8'd128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn1  (btn1),
        .btn2  (btn2),
        .btn3  (btn3),
        .btn4  (btn4),
        .btn5  (btn5),
        .pos1  (pos1),
        .pos2  (pos2),
        .pos3  (pos3),
        .pos4  (pos4),
        .pos5  (pos5),
        .pwm   (pwm)
    );

    always #5 clk = ~clk;

    // Bench-side count of active edges since reset release; edge n is a tick when n%4==0
    // and a frame start when (n-1)%600==0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] b1, input logic [1:0] b2, input logic [1:0] b3,
                                 input logic [1:0] b4, input logic [1:0] b5);
        btn1 = b1;
        btn2 = b2;
        btn3 = b3;
        btn4 = b4;
        btn5 = b5;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic alignTick();
        while (cyc % STEP_DIV != 0) @(negedge clk);
    endtask

    task automatic waitFrameStart();
        while (cyc % PWM_PERIOD != 0) @(negedge clk);
    endtask

    // Counts high clocks per channel across exactly one frame.
    task automatic measureFrame();
        waitFrameStart();
        for (int c = 0; c < 5; c++) pulseLen[c] = 0;
        for (int j = 0; j < int'(PWM_PERIOD); j++) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++)
                if (pwm[c] === 1'b1) pulseLen[c]++;
        end
    endtask

    function automatic pos_t posOf(input int c);
        case (c)
            0:       return pos1;
            1:       return pos2;
            2:       return pos3;
            3:       return pos4;
            default: return pos5;
        endcase
    endfunction

    initial begin
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        waitClocks(3);
        $display("[TB] reset state");
        for (int c = 0; c < 5; c++)
            checkOutput($sformatf("reset_pos%0d", c + 1), posOf(c), 128);
        checkOutput("reset_pwm", pwm, 0);

        rst_n = 1'b1;
        $display("[TB] idle frames after release");
        for (int f = 0; f < 3; f++) begin
            measureFrame();
            for (int c = 0; c < 5; c++)
                checkOutput($sformatf("idle_f%0d_pulse%0d", f, c + 1), pulseLen[c], 272);
        end
        for (int c = 0; c < 5; c++)
            checkOutput($sformatf("idle_pos%0d", c + 1), posOf(c), 128);

        $display("[TB] add ramp on channel 1");
        alignTick();
        applyStimulus(BTN_ADD, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        waitClocks(40);
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        checkOutput("ramp_pos1", pos1, 138);
        checkOutput("ramp_pos2", pos2, 128);
        checkOutput("ramp_pos5", pos5, 128);

        $display("[TB] saturation on channel 2");
        alignTick();
        applyStimulus(BTN_IDLE, BTN_SUB, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        waitClocks(64 * 4);
        checkOutput("sub_slew_pos2", pos2, 64);
        waitClocks((600 - 64) * 4);
        checkOutput("sub_floor_pos2", pos2, 0);
        applyStimulus(BTN_IDLE, BTN_ADD, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        waitClocks(200 * 4);
        checkOutput("add_slew_pos2", pos2, 200);
        waitClocks(100 * 4);
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        checkOutput("add_ceiling_pos2", pos2, 255);
        checkOutput("hold_pos1", pos1, 138);

        $display("[TB] illegal request on channel 3");
        alignTick();
        applyStimulus(BTN_IDLE, BTN_IDLE, 2'b11, BTN_IDLE, BTN_IDLE);
        waitClocks(100 * 4);
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        checkOutput("illegal_pos3", pos3, 128);

        $display("[TB] request between ticks on channel 5");
        alignTick();
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_ADD);
        waitClocks(2);
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        waitClocks(8);
        checkOutput("between_ticks_pos5", pos5, 128);

        $display("[TB] mid-frame update on channel 4");
        waitFrameStart();
        fork
            measureFrame();
            begin
                waitClocks(97);
                applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_ADD, BTN_IDLE);
                waitClocks(3);
                applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
            end
        join
        checkOutput("midframe_cur_pulse4", pulseLen[3], 272);
        checkOutput("midframe_pos4", pos4, 129);
        measureFrame();
        checkOutput("midframe_next_pulse4", pulseLen[3], 274);
        checkOutput("pulse1_pos138", pulseLen[0], 292);
        checkOutput("pulse2_pos255", pulseLen[1], 526);

        $display("[TB] ramp channel 5 to 200");
        alignTick();
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_ADD);
        waitClocks(72 * 4);
        applyStimulus(BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE, BTN_IDLE);
        checkOutput("ramp_pos5", pos5, 200);
        measureFrame();
        checkOutput("pulse5_pos200", pulseLen[4], 416);
        checkOutput("pulse3_pos128", pulseLen[2], 272);

        $display("[TB] reset mid-pulse");
        waitFrameStart();
        waitClocks(50);
        checkOutput("pre_reset_pwm", pwm, 5'b11111);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", pwm, 0);
        checkOutput("async_reset_pos5", pos5, 128);
        checkOutput("async_reset_pos2", pos2, 128);
        @(negedge clk);
        rst_n = 1'b1;
        measureFrame();
        checkOutput("post_reset_pulse5", pulseLen[4], 272);
        checkOutput("post_reset_pulse2", pulseLen[1], 272);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
